// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define LEAD_ZERO_BLANK_EN to replace leading zero digits (BCD3..BCD1) with BLANK_CODE.
module bin_to_bcd_seq #(
  parameter int W = 14,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] bin_in,
  input  logic         start,
  output logic [3:0]   BCD3,
  output logic [3:0]   BCD2,
  output logic [3:0]   BCD1,
  output logic [3:0]   BCD0,
  output logic         busy,
  output logic         done,
  output logic         overflow
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONVERT = 1'b1;
  localparam logic [W-1:0] MAX_VAL = W'(9999);
  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [W-1:0] bin_q, bin_d, sh_bin;
  logic [15:0] scr_q, scr_d, adj, sh_scr, res, bcd_q, bcd_d;
  logic ovf_q, ovf_d, ovo_q, ovo_d, done_q, done_d;
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign adj[4*g+:4] = scr_q[4*g+:4] >= 4'd5 ? scr_q[4*g+:4] + 4'd3 : scr_q[4*g+:4];
  end
  assign sh_scr = {adj[14:0], bin_q[W-1]};
  assign sh_bin = {bin_q[W-2:0], 1'b0};
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [15:0] BCD_RST = {BLANK_CODE, BLANK_CODE, BLANK_CODE, 4'h0};
  logic z3, z2, z1;
  // Blanking stops at the first nonzero digit from the top; units never blank.
  assign z3 = sh_scr[15:12] == 4'h0;
  assign z2 = z3 && sh_scr[11:8] == 4'h0;
  assign z1 = z2 && sh_scr[7:4] == 4'h0;
  assign res = {z3 ? BLANK_CODE : sh_scr[15:12], z2 ? BLANK_CODE : sh_scr[11:8],
                z1 ? BLANK_CODE : sh_scr[7:4], sh_scr[3:0]};
`else
  localparam logic [15:0] BCD_RST = 16'h0000;
  assign res = sh_scr;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    scr_d = scr_q;
    ovf_d = ovf_q;
    bcd_d = bcd_q;
    ovo_d = ovo_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CONVERT;
        bin_d = bin_in > MAX_VAL ? MAX_VAL : bin_in;
        ovf_d = bin_in > MAX_VAL;
        scr_d = '0;
        cnt_d = 4'(W);
      end
    end else begin
      scr_d = sh_scr;
      bin_d = sh_bin;
      cnt_d = cnt_q - 4'd1;
      // Last shift: publish the post-shift scratch on the same edge.
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        bcd_d = res;
        ovo_d = ovf_q;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bin_q <= '0;
      scr_q <= '0;
      ovf_q <= 1'b0;
      bcd_q <= BCD_RST;
      ovo_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      scr_q <= scr_d;
      ovf_q <= ovf_d;
      bcd_q <= bcd_d;
      ovo_q <= ovo_d;
      done_q <= done_d;
    end
  end
  assign {BCD3, BCD2, BCD1, BCD0} = bcd_q;
  assign busy = state_q == CONVERT;
  assign done = done_q;
  assign overflow = ovo_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and random checks of bin_to_bcd_seq against an arithmetic model.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [13:0] bin_in = '0;
  logic start = 1'b0;
  logic [3:0] BCD3, BCD2, BCD1, BCD0;
  logic busy, done, overflow;
  int n_cmp = 0;
  int n_bad = 0;
  bin_to_bcd_seq dut (
    .clk(clk), .reset(reset), .bin_in(bin_in), .start(start),
    .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
    .busy(busy), .done(done), .overflow(overflow)
  );
  always #5 clk = ~clk;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [15:0] RST_DIG = 16'hFFF0;
`else
  localparam logic [15:0] RST_DIG = 16'h0000;
`endif
  function automatic logic [16:0] model(int x);
    int v;
    logic [3:0] d3, d2, d1, d0;
    v = x > 9999 ? 9999 : x;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
`ifdef LEAD_ZERO_BLANK_EN
    if (d3 == 0) begin
      d3 = 4'hF;
      if (d2 == 0) begin
        d2 = 4'hF;
        if (d1 == 0) d1 = 4'hF;
      end
    end
`endif
    return {x > 9999, d3, d2, d1, d0};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Waits up to lim edges for done; returns edges counted (lim+1 on timeout).
  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!done && n <= lim) begin
      tick();
      n++;
    end
  endtask
  task automatic convert(string tag, int x);
    int n;
    logic [16:0] e;
    logic [15:0] prev;
    e = model(x);
    prev = {BCD3, BCD2, BCD1, BCD0};
    bin_in = 14'(x);
    start = 1'b1;
    tick();
    start = 1'b0;
    bin_in = 14'($urandom);
    chk({tag, ":busy"}, 32'(busy), 1);
    chk({tag, ":hold"}, 32'({BCD3, BCD2, BCD1, BCD0}), 32'(prev));
    wait_done(20, n);
    chk({tag, ":lat"}, n, 14);
    chk({tag, ":dig"}, 32'({BCD3, BCD2, BCD1, BCD0}), 32'(e[15:0]));
    chk({tag, ":ovf"}, 32'(overflow), 32'(e[16]));
    chk({tag, ":busy0"}, 32'(busy), 0);
    tick();
    chk({tag, ":pulse"}, 32'(done), 0);
  endtask
  initial begin
    int n, cnt;
    tick();
    tick();
    reset = 1'b0;
    chk("rst:dig", 32'({BCD3, BCD2, BCD1, BCD0}), 32'(RST_DIG));
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:ovf", 32'(overflow), 0);
    convert("d1234", 1234);
    convert("d9999", 9999);
    convert("d16383", 16383);
    convert("d0", 0);
    convert("d7", 7);
    convert("d1005", 1005);
    convert("d10000", 10000);
    // start during conversion is ignored
    bin_in = 14'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin_in = 14'd555;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    repeat (40) begin
      if (done) begin
        cnt++;
        if (cnt == 1) chk("ign:dig", 32'({BCD3, BCD2, BCD1, BCD0}), 32'(model(100)));
      end
      tick();
    end
    chk("ign:ndone", cnt, 1);
    chk("ign:busy", 32'(busy), 0);
    // reset aborts conversion
    bin_in = 14'd4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort:dig", 32'({BCD3, BCD2, BCD1, BCD0}), 32'(RST_DIG));
    chk("abort:busy", 32'(busy), 0);
    chk("abort:ovf", 32'(overflow), 0);
    cnt = 0;
    repeat (20) begin
      if (done) cnt++;
      tick();
    end
    chk("abort:ndone", cnt, 0);
    convert("re4321", 4321);
    // continuous start gives one result every 15 cycles
    bin_in = 14'd42;
    start = 1'b1;
    tick();
    wait_done(20, n);
    chk("cont:first", n, 14);
    chk("cont:dig0", 32'({BCD3, BCD2, BCD1, BCD0}), 32'(model(42)));
    for (int i = 0; i < 3; i++) begin
      tick();
      wait_done(20, n);
      chk("cont:gap", n + 1, 15);
      chk("cont:dig", 32'({BCD3, BCD2, BCD1, BCD0}), 32'(model(42)));
    end
    start = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 30; i++) convert("rand", int'($urandom_range(0, 16383)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
